// File: rtl/calc_op_sequencer_pkg.sv
// Shared definitions for the calculator sequencer: opcodes, FSM encoding, default width.
package calc_pkg;

    localparam int CALC_WIDTH = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } state_e;

endpackage

// File: rtl/calc_op_sequencer_if.sv
// Request/result bundle between the operand registers and the sequencer.
interface calc_op_sequencer_if #(
    parameter int WIDTH = calc_pkg::CALC_WIDTH
);
    logic               start;
    logic [1:0]         opcode;
    logic [WIDTH-1:0]   operand_a;
    logic [WIDTH-1:0]   operand_b;
    logic [2*WIDTH-1:0] result;
    logic               negative;
    logic               error;
    logic               busy;
    logic               done;

    modport master (
        output start, opcode, operand_a, operand_b,
        input  result, negative, error, busy, done
    );

    modport slave (
        input  start, opcode, operand_a, operand_b,
        output result, negative, error, busy, done
    );
endinterface

// File: rtl/calc_op_sequencer_iter_unit.sv
// Iterative datapath: shift-add multiply and restoring divide sharing one 2*WIDTH register.
// For divide the register holds {remainder, quotient/dividend} and shifts left each step.
module calc_iter_unit #(
    parameter int WIDTH = 4,
    parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step_en,
    input  logic               op_div,
    input  logic [CW-1:0]      count,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    output logic [WIDTH-1:0]   a_out,
    output logic [WIDTH-1:0]   b_out,
    output logic [2*WIDTH-1:0] acc_nxt
);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    logic [2*WIDTH-1:0] addend;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic               ge;

    always_comb begin
        addend = (2*WIDTH)'(a_q) << count;
        // Remainder stays below the divisor, so its doubled value plus the next bit fits WIDTH+1 bits.
        trial  = acc_q[2*WIDTH-1:WIDTH-1];
        diff   = trial - {1'b0, b_q};
        ge     = (trial >= {1'b0, b_q});

        acc_nxt = acc_q;
        if (op_div) begin
            acc_nxt = {(ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), acc_q[WIDTH-2:0], ge};
        end else if (b_q[count]) begin
            acc_nxt = acc_q + addend;
        end
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        acc_d = acc_q;
        if (load) begin
            a_d   = a_in;
            b_d   = b_in;
            acc_d = op_div ? {{WIDTH{1'b0}}, a_in} : '0;
        end else if (step_en) begin
            acc_d = acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out = a_q;
    assign b_out = b_q;

endmodule

// File: rtl/calc_op_sequencer.sv
// Calculator op sequencer: accepts an op on start, runs it (1 cycle or WIDTH cycles),
// then presents registered result with a one-cycle done pulse.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    calc_op_sequencer_if.slave   bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [CW-1:0]      count_q, count_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               negative_q, negative_d;
    logic               error_q, error_d;
    logic               done_q, done_d;

    logic               load;
    logic               step_en;
    logic               op_div_sel;
    logic [WIDTH-1:0]   a_r, b_r;
    logic [2*WIDTH-1:0] acc_nxt;

    // While loading, the datapath must see the incoming opcode to seed its register.
    assign op_div_sel = load ? (bus.opcode == OP_DIV) : (op_q == OP_DIV);

    calc_iter_unit #(.WIDTH(WIDTH), .CW(CW)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step_en (step_en),
        .op_div  (op_div_sel),
        .count   (count_q),
        .a_in    (bus.operand_a),
        .b_in    (bus.operand_b),
        .a_out   (a_r),
        .b_out   (b_r),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        count_d    = count_q;
        result_d   = result_q;
        negative_d = negative_q;
        error_d    = error_q;
        done_d     = 1'b0;
        load       = 1'b0;
        step_en    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    op_d       = bus.opcode;
                    count_d    = '0;
                    negative_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = S_RUN;
                end
            end

            S_RUN: begin
                unique case (op_q)
                    OP_ADD: begin
                        result_d = (2*WIDTH)'(a_r) + (2*WIDTH)'(b_r);
                        done_d   = 1'b1;
                        state_d  = S_FIN;
                    end
                    OP_SUB: begin
                        // Modular 2*WIDTH subtraction yields the sign-extended difference directly.
                        result_d   = (2*WIDTH)'(a_r) - (2*WIDTH)'(b_r);
                        negative_d = (a_r < b_r);
                        done_d     = 1'b1;
                        state_d    = S_FIN;
                    end
                    default: begin
                        if (op_q == OP_DIV && b_r == '0) begin
                            error_d  = 1'b1;
                            result_d = '1;
                            done_d   = 1'b1;
                            state_d  = S_FIN;
                        end else begin
                            step_en = 1'b1;
                            if (count_q == LAST) begin
                                result_d = acc_nxt;
                                done_d   = 1'b1;
                                state_d  = S_FIN;
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                    end
                endcase
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_ADD;
            count_q    <= '0;
            result_q   <= '0;
            negative_q <= 1'b0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            count_q    <= count_d;
            result_q   <= result_d;
            negative_q <= negative_d;
            error_q    <= error_d;
            done_q     <= done_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.negative = negative_q;
    assign bus.error    = error_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer at WIDTH=4; all checks sampled on the falling edge.
module tb_calc_op_sequencer;
    import calc_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    calc_op_sequencer_if #(.WIDTH(W)) bus ();

    calc_op_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Issues one op and checks latency, outputs in FIN, and the return to idle.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_lat, input logic [7:0] exp_res,
                          input logic exp_neg, input logic exp_err);
        int k;
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.operand_a = a; bus.operand_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.operand_a = ~a; bus.operand_b = ~b; bus.opcode = ~op;
        chk({tag, "_busy"}, 16'(bus.busy), 16'd1);
        k = 1;
        while (bus.done !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 16'(k), 16'(exp_lat));
        chk({tag, "_res"}, 16'(bus.result), 16'(exp_res));
        chk({tag, "_neg"}, 16'(bus.negative), 16'(exp_neg));
        chk({tag, "_err"}, 16'(bus.error), 16'(exp_err));
        @(negedge clk);
        chk({tag, "_idle"}, {14'd0, bus.busy, bus.done}, 16'd0);
        chk({tag, "_hold"}, 16'(bus.result), 16'(exp_res));
    endtask

    initial begin
        int k;
        int ndone;
        int dcyc[$];

        rst = 1'b1;
        bus.start = 1'b0; bus.opcode = OP_ADD; bus.operand_a = '0; bus.operand_b = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {bus.result, 4'd0, bus.negative, bus.error, bus.busy, bus.done}, 16'd0);
        rst = 1'b0;

        run_op("mul15x15", OP_MUL, 4'd15, 4'd15, 5, 8'hE1, 1'b0, 1'b0);
        run_op("sub7m9",   OP_SUB, 4'd7,  4'd9,  2, 8'hFE, 1'b1, 1'b0);
        run_op("add15p15", OP_ADD, 4'd15, 4'd15, 2, 8'h1E, 1'b0, 1'b0);
        run_op("sub9m7",   OP_SUB, 4'd9,  4'd7,  2, 8'h02, 1'b0, 1'b0);
        run_op("div13d4",  OP_DIV, 4'd13, 4'd4,  5, 8'h13, 1'b0, 1'b0);
        run_op("div5d0",   OP_DIV, 4'd5,  4'd0,  2, 8'hFF, 1'b0, 1'b1);
        run_op("div15d1",  OP_DIV, 4'd15, 4'd1,  5, 8'h0F, 1'b0, 1'b0);
        run_op("mul0x9",   OP_MUL, 4'd0,  4'd9,  5, 8'h00, 1'b0, 1'b0);

        // Start pulses throughout a MUL, including its FIN cycle, must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.operand_a = 4'd15; bus.operand_b = 4'd15;
        ndone = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.opcode = OP_ADD; bus.operand_a = 4'd1; bus.operand_b = 4'd1;
            if (bus.done === 1'b1) ndone++;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("ign_busy", 16'(bus.busy), 16'd0);
        chk("ign_ndone", 16'(ndone), 16'd1);
        chk("ign_res", 16'(bus.result), 16'hE1);
        @(negedge clk);
        chk("ign_still_idle", {14'd0, bus.busy, bus.done}, 16'd0);

        // Reset in the middle of a MUL aborts it with no done.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.operand_a = 4'd7; bus.operand_b = 4'd7;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outs", {bus.result, 4'd0, bus.negative, bus.error, bus.busy, bus.done}, 16'd0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
        end
        chk("rst_no_done", 16'(ndone), 16'd0);
        run_op("mul3x5", OP_MUL, 4'd3, 4'd5, 5, 8'h0F, 1'b0, 1'b0);

        // Start held high: back-to-back MULs spaced by latency + 1.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.operand_a = 4'd2; bus.operand_b = 4'd3;
        k = 0;
        while (dcyc.size() < 3 && k < 40) begin
            @(negedge clk);
            k++;
            if (bus.done === 1'b1) begin
                dcyc.push_back(k);
                chk("held_res", 16'(bus.result), 16'h06);
            end
        end
        bus.start = 1'b0;
        chk("held_count", 16'(dcyc.size()), 16'd3);
        if (dcyc.size() == 3) begin
            chk("held_first", 16'(dcyc[0]), 16'd5);
            chk("held_gap1", 16'(dcyc[1] - dcyc[0]), 16'd6);
            chk("held_gap2", 16'(dcyc[2] - dcyc[1]), 16'd6);
        end
        k = 0;
        while (bus.busy === 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("held_drain", 16'(bus.busy), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
